// File: rtl/aes192_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes192_cipher_iter
// Description : Iterative AES-192 encryption datapath, one round per clock.
//               Takes the 13 expanded round keys and a 128-bit plaintext block
//               and returns the ciphertext through a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module aes192_cipher_iter #(
  parameter int NR = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [0:127]            plaintext,
  input  logic [0:128*(NR+1)-1]   keys,
  output logic                    busy,
  output logic                    done,
  output logic [0:127]            ciphertext
);

  localparam logic [3:0] RND_LAST = 4'(NR);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] st_q, st_d;
  logic [0:127] ct_q, ct_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [0:127] sub_w;
  logic [0:127] shift_w;
  logic [0:127] mix_w;
  logic [0:127] rk_w;

  // FIPS-197 S-box, selected by high nibble then low nibble
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [0:127] row;
    case (x[7:4])
      4'h0:    row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1:    row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2:    row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3:    row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4:    row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5:    row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6:    row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7:    row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8:    row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9:    row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha:    row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb:    row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc:    row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd:    row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he:    row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{x[3:0], 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round key for the current round; keys must be held stable by the source
  assign rk_w = keys[{rnd_q, 7'd0} +: 128];

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sub_w[i*8 +: 8] = sbox(st_q[i*8 +: 8]);
  end

  // Byte index is 4*column + row; row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign shift_w[(4*c+r)*8 +: 8] = sub_w[(4*((c+r)%4)+r)*8 +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shift_w[(4*c)*8   +: 8];
    assign a1 = shift_w[(4*c+1)*8 +: 8];
    assign a2 = shift_w[(4*c+2)*8 +: 8];
    assign a3 = shift_w[(4*c+3)*8 +: 8];
    assign mix_w[(4*c)*8   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mix_w[(4*c+1)*8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mix_w[(4*c+2)*8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mix_w[(4*c+3)*8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Next-state logic: load on start, iterate rounds, finish without MixColumns
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = plaintext ^ keys[0:127];
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd_q == RND_LAST) begin
          ct_d    = shift_w ^ rk_w;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rnd_d   = 4'd0;
          state_d = IDLE;
        end else begin
          st_d  = mix_w ^ rk_w;
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any run and clears the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule
`default_nettype wire
